// File: rtl/led_breath_multi.sv
// led_breath_multi: N-channel breathing-LED PWM driver.
// Each channel ramps brightness 0 -> BMAX -> (hold) -> 0 in a triangle and
// repeats; the brightness drives a per-channel PWM whose duty only changes at
// PWM period boundaries so the output never glitches mid-period.
// Optional feature macro: LED_BREATH_GAMMA_EN selects a squared (perceptual)
// brightness-to-duty map; without it duty follows brightness linearly.
module led_breath_multi #(
  parameter int N_LED      = 8,
  parameter int PWM_BITS   = 8,
  parameter int STEP_DIV   = 64,
  parameter int HOLD_TICKS = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_LED-1:0] led_en,
  input  logic             sync_restart,
  output logic [N_LED-1:0] led_out,
  output logic [N_LED-1:0] cycle_done
);

  localparam int PS_W   = $clog2(STEP_DIV + 1);
  localparam int HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  localparam logic [PWM_BITS-1:0] BMAX      = '1;
  localparam logic [PWM_BITS-1:0] BMAX_M1   = BMAX - 1'b1;
  localparam logic [PWM_BITS-1:0] B_ONE     = PWM_BITS'(1);
  localparam logic [PS_W-1:0]     PS_LAST   = PS_W'(STEP_DIV - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_RISE,
    ST_HOLD,
    ST_FALL
  } ch_state_t;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PS_W-1:0]     prescaler;
  logic                wrap;
  logic                step_tick;

  assign wrap      = (pwm_cnt == BMAX);
  assign step_tick = wrap && (prescaler == PS_LAST);

  // Shared timebase: PWM counter plus the period prescaler that yields step_tick; a restart re-aligns both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt   <= '0;
      prescaler <= '0;
    end else if (sync_restart) begin
      pwm_cnt   <= '0;
      prescaler <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (wrap) begin
        prescaler <= (prescaler == PS_LAST) ? '0 : prescaler + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N_LED; i++) begin : g_ch
    ch_state_t           state;
    logic [PWM_BITS-1:0] b;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] duty_src;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                out_q;
    logic                done_q;

`ifdef LED_BREATH_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq;
    assign sq       = b * b;
    assign duty_src = PWM_BITS'(sq >> PWM_BITS);
`else
    assign duty_src = b;
`endif

    // Channel breath FSM with registered PWM output; disable beats restart beats step_tick
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state    <= ST_OFF;
        b        <= '0;
        duty     <= '0;
        hold_cnt <= '0;
        out_q    <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        out_q  <= led_en[i] && (duty > pwm_cnt);
        done_q <= 1'b0;
        if (!led_en[i]) begin
          state    <= ST_OFF;
          b        <= '0;
          duty     <= '0;
          hold_cnt <= '0;
        end else if (sync_restart) begin
          state    <= ST_RISE;
          b        <= '0;
          duty     <= '0;
          hold_cnt <= '0;
        end else begin
          if (wrap) begin
            duty <= duty_src;
          end
          case (state)
            ST_OFF: begin
              state <= ST_RISE;
              b     <= '0;
            end
            ST_RISE: begin
              if (step_tick) begin
                b <= b + 1'b1;
                if (b == BMAX_M1) begin
                  state <= (HOLD_TICKS > 0) ? ST_HOLD : ST_FALL;
                end
              end
            end
            ST_HOLD: begin
              if (step_tick) begin
                if (hold_cnt == HOLD_LAST) begin
                  state    <= ST_FALL;
                  hold_cnt <= '0;
                end else begin
                  hold_cnt <= hold_cnt + 1'b1;
                end
              end
            end
            ST_FALL: begin
              if (step_tick) begin
                b <= b - 1'b1;
                if (b == B_ONE) begin
                  state  <= ST_RISE;
                  done_q <= 1'b1;
                end
              end
            end
            default: begin
              state <= ST_OFF;
              b     <= '0;
            end
          endcase
        end
      end
    end

    assign led_out[i]    = out_q;
    assign cycle_done[i] = done_q;
  end

endmodule

// File: tb/tb_led_breath_multi.sv
// tb_led_breath_multi: randomized and directed bench for led_breath_multi.
// The reference model tracks, per channel, how many step ticks have elapsed
// since the channel last started a breath and derives brightness from the
// triangular breath shape with plain arithmetic.
module tb_led_breath_multi;

  localparam int N          = 8;
  localparam int PB         = 4;
  localparam int SD         = 2;
  localparam int HT         = 1;
  localparam int BMAX       = (1 << PB) - 1;
  localparam int PER        = 1 << PB;
  localparam int TICK_CLK   = SD * PER;
  localparam int BREATH     = 2 * BMAX + HT;
  localparam int BREATH_CLK = BREATH * TICK_CLK;
`ifdef LED_BREATH_GAMMA_EN
  localparam int HI_AT_BMAX = 14;
`else
  localparam int HI_AT_BMAX = 15;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] led_en;
  logic         sync_restart;
  logic [N-1:0] led_out;
  logic [N-1:0] cycle_done;

  int checkCount = 0;
  int failCount  = 0;

  // model state
  int           mAlign;
  bit           mActive [N];
  int           mTicks  [N];
  int           mDuty   [N];
  logic [N-1:0] mOut;
  logic [N-1:0] mDone;

  always #5 clk = ~clk;

  led_breath_multi #(
    .N_LED      (N),
    .PWM_BITS   (PB),
    .STEP_DIV   (SD),
    .HOLD_TICKS (HT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .led_en       (led_en),
    .sync_restart (sync_restart),
    .led_out      (led_out),
    .cycle_done   (cycle_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int triB(input int t);
    int p;
    p = t % BREATH;
    if (p <= BMAX) return p;
    else if (p <= BMAX + HT) return BMAX;
    else return 2 * BMAX + HT - p;
  endfunction

  function automatic int dutyOf(input int bright);
`ifdef LED_BREATH_GAMMA_EN
    return (bright * bright) >> PB;
`else
    return bright;
`endif
  endfunction

  function automatic void modelReset();
    mAlign = 0;
    mOut   = '0;
    mDone  = '0;
    for (int i = 0; i < N; i++) begin
      mActive[i] = 1'b0;
      mTicks[i]  = 0;
      mDuty[i]   = 0;
    end
  endfunction

  // advance the model across one rising edge with the given inputs
  function automatic void modelStep(input logic [N-1:0] en, input logic rs);
    int pwmOld;
    bit wrap;
    bit tick;
    pwmOld = mAlign % PER;
    wrap   = (pwmOld == BMAX);
    tick   = ((mAlign % TICK_CLK) == TICK_CLK - 1);
    for (int i = 0; i < N; i++) begin
      mOut[i]  = en[i] && (mDuty[i] > pwmOld);
      mDone[i] = 1'b0;
      if (!en[i]) begin
        mActive[i] = 1'b0;
        mTicks[i]  = 0;
        mDuty[i]   = 0;
      end else if (rs) begin
        mActive[i] = 1'b1;
        mTicks[i]  = 0;
        mDuty[i]   = 0;
      end else if (!mActive[i]) begin
        mActive[i] = 1'b1;
        mTicks[i]  = 0;
      end else begin
        if (wrap) mDuty[i] = dutyOf(triB(mTicks[i]));
        if (tick) begin
          mTicks[i] = mTicks[i] + 1;
          if (mTicks[i] == BREATH) begin
            mTicks[i] = 0;
            mDone[i]  = 1'b1;
          end
        end
      end
    end
    mAlign = rs ? 0 : (mAlign + 1) % TICK_CLK;
  endfunction

  // drive one clock of inputs (called at a negedge), then compare after the edge
  task automatic applyStimulus(input logic [N-1:0] en, input logic rs);
    led_en       = en;
    sync_restart = rs;
    modelStep(en, rs);
    @(negedge clk);
    checkOutput("led_out", led_out, mOut);
    checkOutput("cycle_done", cycle_done, mDone);
  endtask

  task automatic applyReset(input int cycles);
    rst_n        = 1'b0;
    led_en       = '0;
    sync_restart = 1'b0;
    modelReset();
    #1;
    checkOutput("reset_led_out", led_out, 0);
    checkOutput("reset_cycle_done", cycle_done, 0);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      checkOutput("reset_led_out", led_out, 0);
      checkOutput("reset_cycle_done", cycle_done, 0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    int           doneAt[$];
    int           found;
    int           hi;
    int           firstDone;
    logic [N-1:0] firstDoneVal;
    logic [N-1:0] en;

    rst_n        = 1'b0;
    led_en       = '0;
    sync_restart = 1'b0;
    modelReset();
    @(negedge clk);
    applyReset(3);

    // Test 1: reset mid-ramp while ch0 sits at b=7
    found = 0;
    for (int k = 0; k < 2000; k++) begin
      if (mActive[0] && triB(mTicks[0]) == 7) begin
        found = 1;
        break;
      end
      applyStimulus(8'h01, 1'b0);
    end
    checkOutput("s1_reach_b7", found, 1);
    for (int k = 0; k < 5; k++) applyStimulus(8'h01, 1'b0);
    applyReset(4);

    // Test 2: ch0 alone from reset, cycle_done every full breath
    for (int k = 1; k <= 2100; k++) begin
      applyStimulus(8'h01, 1'b0);
      if (cycle_done[0]) doneAt.push_back(k);
    end
    checkOutput("s2_done_count", doneAt.size(), 2);
    if (doneAt.size() >= 2) begin
      checkOutput("s2_first_done", doneAt[0], BREATH_CLK);
      checkOutput("s2_done_interval", doneAt[1] - doneAt[0], BREATH_CLK);
    end

    // Test 3: drop ch0 mid-rise at b=9, then re-enable
    found = 0;
    for (int k = 0; k < 3000; k++) begin
      if (mActive[0] && (mTicks[0] % BREATH) == 9) begin
        found = 1;
        break;
      end
      applyStimulus(8'h01, 1'b0);
    end
    checkOutput("s3_reach_b9", found, 1);
    applyStimulus(8'h00, 1'b0);
    checkOutput("s3_off_next_clk", led_out[0], 0);
    for (int k = 0; k < 40; k++) begin
      applyStimulus(8'h00, 1'b0);
      checkOutput("s3_no_done", cycle_done, 0);
    end
    hi = 0;
    for (int k = 0; k < TICK_CLK; k++) begin
      applyStimulus(8'h01, 1'b0);
      hi += int'(led_out[0]);
    end
    checkOutput("s3_restart_dark", hi, 0);

    // Test 4 + 6: staggered enables, then sync_restart aligns every channel
    en = 8'h01;
    for (int i = 1; i < N; i++) begin
      en[i] = 1'b1;
      for (int k = 0; k < int'($urandom_range(5, 60)); k++) applyStimulus(en, 1'b0);
    end
    applyStimulus(8'hFF, 1'b1);
    hi           = 0;
    firstDone    = -1;
    firstDoneVal = '0;
    for (int k = 1; k <= 1100; k++) begin
      applyStimulus(8'hFF, 1'b0);
      if (k >= 2) checkOutput("s4_aligned", (led_out == 8'h00) || (led_out == 8'hFF), 1);
      if (k >= 513 && k <= 528) hi += int'(led_out[0]);
      if (firstDone < 0 && cycle_done != '0) begin
        firstDone    = k;
        firstDoneVal = cycle_done;
      end
    end
    checkOutput("s4_done_time", firstDone, BREATH_CLK);
    checkOutput("s4_done_all", firstDoneVal, 8'hFF);
    checkOutput("s6_hi_at_bmax", hi, HI_AT_BMAX);

    // Test 5: sync_restart in the same clock ch3 is dropped
    for (int k = 0; k < int'($urandom_range(50, 400)); k++) applyStimulus(8'hFF, 1'b0);
    applyStimulus(8'hF7, 1'b1);
    for (int k = 0; k < 300; k++) begin
      applyStimulus(8'hF7, 1'b0);
      checkOutput("s5_ch3_off", led_out[3], 0);
    end

    // Random phase: sparse enable toggles, occasional restarts, one mid-run reset
    en = 8'hF7;
    for (int k = 0; k < 4000; k++) begin
      if (k == 2000) begin
        applyReset(2);
        en = 8'hFF;
      end
      if ($urandom_range(0, 99) < 3) en[$urandom_range(0, N - 1)] ^= 1'b1;
      applyStimulus(en, ($urandom_range(0, 299) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
